// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer state type and fetch/branch constants
package cpu_pkg;
  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} pc_state_t;
  localparam int INSTR_BYTES = 4;
  localparam int BR_SHIFT = 2;
endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc: br_pc + (sext(offset) << BR_SHIFT), offset picked by UncondBr
// ports: UncondBr selects BrAddr26 over CondAddr19; br_pc is the branch PC; target wraps at ADDR_W bits
module branch_target_calc import cpu_pkg::*; #(
  parameter int ADDR_W = 64
) (
  input  logic              UncondBr,
  input  logic [18:0]       CondAddr19,
  input  logic [25:0]       BrAddr26,
  input  logic [ADDR_W-1:0] br_pc,
  output logic [ADDR_W-1:0] target
);
  logic [ADDR_W-1:0] off;
  always_comb begin
    off = UncondBr ? {{(ADDR_W-26){BrAddr26[25]}}, BrAddr26} : {{(ADDR_W-19){CondAddr19[18]}}, CondAddr19};
    target = br_pc + (off << BR_SHIFT);
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC owner choosing advance, branch, stall, halt or external load
// ports: clk/reset (sync, active high); stall, br_valid, BrTaken, UncondBr, CondAddr19, BrAddr26, br_pc from
// hazard/branch logic; halt_req from decode; ext_req/pc_ext/ext_ack external load handshake;
// pc_out, fetch_valid, flush, halted towards instruction fetch
module pc_sequencer import cpu_pkg::*; #(
  parameter int ADDR_W = 64,
  parameter int DRAIN_CYCLES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              BrTaken,
  input  logic              UncondBr,
  input  logic [18:0]       CondAddr19,
  input  logic [25:0]       BrAddr26,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic              halt_req,
  input  logic              ext_req,
  input  logic [ADDR_W-1:0] pc_ext,
  output logic              ext_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_valid,
  output logic              flush,
  output logic              halted
);
  pc_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [ADDR_W-1:0] pc_n, target;
  logic ack_n, req, taken;
  branch_target_calc #(.ADDR_W(ADDR_W)) u_target (
    .UncondBr(UncondBr),
    .CondAddr19(CondAddr19),
    .BrAddr26(BrAddr26),
    .br_pc(br_pc),
    .target(target)
  );
  // a request still high during its own ack cycle is the old one
  assign req = ext_req & ~ext_ack;
  assign taken = br_valid & BrTaken;
  assign fetch_valid = state == RUN;
  assign halted = state == HALT;
  assign flush = (state == RUN) & ~req & taken;
  always_comb begin
    state_n = state;
    pc_n = pc_out;
    cnt_n = cnt;
    ack_n = 1'b0;
    case (state)
      BOOT: state_n = RUN;
      RUN:
        if (req) begin
          state_n = DRAIN;
          cnt_n = '0;
        end else if (taken) pc_n = target;
        else if (halt_req) state_n = HALT;
        else if (!stall) pc_n = pc_out + ADDR_W'(INSTR_BYTES);
      DRAIN:
        if (!ext_req) state_n = RUN;
        else if (cnt == 4'(DRAIN_CYCLES - 1)) begin
          state_n = RUN;
          pc_n = pc_ext;
          ack_n = 1'b1;
        end else cnt_n = cnt + 4'd1;
      HALT:
        if (ext_req) begin
          state_n = DRAIN;
          cnt_n = '0;
        end
      default: state_n = BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc_out <= RESET_PC;
      cnt <= '0;
      ext_ack <= 1'b0;
    end else begin
      state <= state_n;
      pc_out <= pc_n;
      cnt <= cnt_n;
      ext_ack <= ack_n;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for the fetch PC sequencer
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset, stall, br_valid, BrTaken, UncondBr, halt_req, ext_req;
  logic ext_ack, fetch_valid, flush, halted;
  logic [18:0] CondAddr19;
  logic [25:0] BrAddr26;
  logic [63:0] br_pc, pc_ext, pc_out;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pc_sequencer #(.ADDR_W(64), .DRAIN_CYCLES(4), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .BrTaken(BrTaken),
    .UncondBr(UncondBr), .CondAddr19(CondAddr19), .BrAddr26(BrAddr26), .br_pc(br_pc),
    .halt_req(halt_req), .ext_req(ext_req), .pc_ext(pc_ext), .ext_ack(ext_ack),
    .pc_out(pc_out), .fetch_valid(fetch_valid), .flush(flush), .halted(halted)
  );
  typedef struct packed {
    logic rst, st, hl, er;
    logic [63:0] pe;
    logic bv, bt, un;
    logic [18:0] c19;
    logic [25:0] b26;
    logic [63:0] bp;
  } stim_t;
  typedef struct packed {
    logic [63:0] pc;
    logic fv, fl, ak, hd;
  } obs_t;
  obs_t sb[$];
  localparam stim_t IDLE = '0;
  function automatic stim_t mk(logic rst, st, hl, er, logic [63:0] pe, logic bv, bt, un,
                               logic [18:0] c19, logic [25:0] b26, logic [63:0] bp);
    return {rst, st, hl, er, pe, bv, bt, un, c19, b26, bp};
  endfunction
  function automatic obs_t ob(logic [63:0] pc, logic fv, fl, ak, hd);
    return {pc, fv, fl, ak, hd};
  endfunction
  function automatic obs_t cur();
    return {pc_out, fetch_valid, flush, ext_ack, halted};
  endfunction
  task automatic apply(stim_t x);
    {reset, stall, halt_req, ext_req, pc_ext, br_valid, BrTaken, UncondBr, CondAddr19, BrAddr26, br_pc} = x;
  endtask
  task automatic load_pc(logic [63:0] v);
    repeat (5) begin
      apply(mk(0, 0, 0, 1, v, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
    end
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    stim_t s[$];
    obs_t e[$];
    obs_t got, want;
    repeat (5) begin s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ob(0, 0, 0, 0, 0)); end
    s.push_back(IDLE); e.push_back(ob(0, 0, 0, 0, 0));
    s.push_back(IDLE); e.push_back(ob(64'h0, 1, 0, 0, 0));
    s.push_back(IDLE); e.push_back(ob(64'h4, 1, 0, 0, 0));
    s.push_back(IDLE); e.push_back(ob(64'h8, 1, 0, 0, 0));
    s.push_back(IDLE); e.push_back(ob(64'hC, 1, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk); checks++; got = cur(); want = sb.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d] got pc=%h vfah=%b want pc=%h vfah=%b", i, got.pc, got[3:0], want.pc, want[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_branch();
    stim_t s[$];
    obs_t e[$];
    obs_t got, want;
    load_pc(64'h100);
    s.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 19'h7FFFE, 0, 64'hF8));       e.push_back(ob(64'h100, 1, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 19'h7FFFE, 0, 64'h200));      e.push_back(ob(64'hF0, 1, 1, 0, 0));
    s.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 0, 26'h10, 64'h1000));        e.push_back(ob(64'h1F8, 1, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 19'h7FFFE, 0, 64'h500));      e.push_back(ob(64'h1040, 1, 0, 0, 0));
    s.push_back(IDLE);                                                   e.push_back(ob(64'h1044, 1, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 26'h3FFFFFF, 64'h2000));   e.push_back(ob(64'h1048, 1, 1, 0, 0));
    s.push_back(IDLE);                                                   e.push_back(ob(64'h1FFC, 1, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk); checks++; got = cur(); want = sb.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL branch[%0d] got pc=%h vfah=%b want pc=%h vfah=%b", i, got.pc, got[3:0], want.pc, want[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_stall();
    stim_t s[$];
    obs_t e[$];
    obs_t got, want;
    load_pc(64'h40);
    repeat (3) begin s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ob(64'h40, 1, 0, 0, 0)); end
    s.push_back(IDLE); e.push_back(ob(64'h40, 1, 0, 0, 0));
    s.push_back(IDLE); e.push_back(ob(64'h44, 1, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk); checks++; got = cur(); want = sb.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL stall[%0d] got pc=%h vfah=%b want pc=%h vfah=%b", i, got.pc, got[3:0], want.pc, want[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_ext_drain();
    stim_t s[$];
    obs_t e[$];
    obs_t got, want;
    load_pc(64'h200);
    s.push_back(mk(0, 0, 0, 1, 64'h8000, 1, 1, 0, 19'h7FFFE, 0, 64'hF8)); e.push_back(ob(64'h200, 1, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 64'h8000, 0, 0, 0, 0, 0, 0));              e.push_back(ob(64'h200, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 64'h8000, 1, 1, 0, 19'h10, 0, 64'h40));    e.push_back(ob(64'h200, 0, 0, 0, 0));
    s.push_back(mk(0, 1, 1, 1, 64'h8000, 0, 0, 0, 0, 0, 0));              e.push_back(ob(64'h200, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 64'h8000, 0, 0, 0, 0, 0, 0));              e.push_back(ob(64'h200, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 64'h8000, 0, 0, 0, 0, 0, 0));              e.push_back(ob(64'h8000, 1, 0, 1, 0));
    s.push_back(IDLE);                                                    e.push_back(ob(64'h8004, 1, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 64'h9000, 0, 0, 0, 0, 0, 0));              e.push_back(ob(64'h8008, 1, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 64'h9000, 0, 0, 0, 0, 0, 0));              e.push_back(ob(64'h8008, 0, 0, 0, 0));
    s.push_back(IDLE);                                                    e.push_back(ob(64'h8008, 0, 0, 0, 0));
    s.push_back(IDLE);                                                    e.push_back(ob(64'h8008, 1, 0, 0, 0));
    s.push_back(IDLE);                                                    e.push_back(ob(64'h800C, 1, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk); checks++; got = cur(); want = sb.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL ext_drain[%0d] got pc=%h vfah=%b want pc=%h vfah=%b", i, got.pc, got[3:0], want.pc, want[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_halt();
    stim_t s[$];
    obs_t e[$];
    obs_t got, want;
    load_pc(64'h30);
    s.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ob(64'h30, 1, 0, 0, 0));
    repeat (10) begin
      s.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 19'h7FFFE, 0, 64'h100)); e.push_back(ob(64'h30, 0, 0, 0, 1));
    end
    s.push_back(mk(0, 0, 0, 1, 64'h0, 0, 0, 0, 0, 0, 0)); e.push_back(ob(64'h30, 0, 0, 0, 1));
    repeat (4) begin s.push_back(mk(0, 0, 0, 1, 64'h0, 0, 0, 0, 0, 0, 0)); e.push_back(ob(64'h30, 0, 0, 0, 0)); end
    s.push_back(IDLE); e.push_back(ob(64'h0, 1, 0, 1, 0));
    s.push_back(IDLE); e.push_back(ob(64'h4, 1, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk); checks++; got = cur(); want = sb.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL halt[%0d] got pc=%h vfah=%b want pc=%h vfah=%b", i, got.pc, got[3:0], want.pc, want[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_drain();
    stim_t s[$];
    obs_t e[$];
    obs_t got, want;
    load_pc(64'h500);
    s.push_back(mk(0, 0, 0, 1, 64'h900, 0, 0, 0, 0, 0, 0)); e.push_back(ob(64'h500, 1, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 64'h900, 0, 0, 0, 0, 0, 0)); e.push_back(ob(64'h500, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 0, 1, 64'h900, 0, 0, 0, 0, 0, 0)); e.push_back(ob(64'h500, 0, 0, 0, 0));
    s.push_back(IDLE); e.push_back(ob(64'h0, 0, 0, 0, 0));
    s.push_back(IDLE); e.push_back(ob(64'h0, 1, 0, 0, 0));
    s.push_back(IDLE); e.push_back(ob(64'h4, 1, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk); checks++; got = cur(); want = sb.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL reset_drain[%0d] got pc=%h vfah=%b want pc=%h vfah=%b", i, got.pc, got[3:0], want.pc, want[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_wrap();
    stim_t s[$];
    obs_t e[$];
    obs_t got, want;
    load_pc(64'hFFFF_FFFF_FFFF_FFFC);
    s.push_back(IDLE);                                              e.push_back(ob(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 19'h7FFFE, 0, 64'h4));   e.push_back(ob(64'h0, 1, 1, 0, 0));
    s.push_back(IDLE);                                              e.push_back(ob(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0));
    s.push_back(IDLE);                                              e.push_back(ob(64'h0, 1, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk); checks++; got = cur(); want = sb.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL wrap[%0d] got pc=%h vfah=%b want pc=%h vfah=%b", i, got.pc, got[3:0], want.pc, want[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    test_reset();
    test_branch();
    test_stall();
    test_ext_drain();
    test_halt();
    test_reset_drain();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Sequencing controller that owns and drives the fetch PC register of the pipelined ARM core.
- Each cycle it selects among sequential advance, taken-branch redirect, hazard stall, halt, and an externally requested PC load.
- It generates the IF/ID flush and fetch-valid qualifiers.
- Sits between hazard/branch-resolution logic and instruction memory.

Parameters:
ADDR_W, 64, PC and address width
DRAIN_CYCLES, 4, cycles fetch is suppressed before an external load commits (legal range 1..15)
RESET_PC, 64'h0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC this cycle
br_valid  in  1  branch resolved this cycle
BrTaken  in  1  resolved branch is taken (qualified by br_valid)
UncondBr  in  1  1: offset = BrAddr26, 0: offset = CondAddr19
CondAddr19  in  19  conditional branch word offset, signed
BrAddr26  in  26  unconditional branch word offset, signed
br_pc  in  ADDR_W  PC of the resolving branch instruction
halt_req  in  1  decode saw HALT; stop fetching
ext_req  in  1  external PC load request, level, held until ext_ack
pc_ext  in  ADDR_W  external load value, stable while ext_req=1
ext_ack  out  1  one-cycle pulse: external load committed
pc_out  out  ADDR_W  current fetch PC (registered)
fetch_valid  out  1  pc_out is a valid fetch address this cycle
flush  out  1  kill IF/ID contents this cycle (combinational)
halted  out  1  sequencer in HALT

Behaviour:
- Reset, sampled at the clock edge, overrides everything, including mid-DRAIN: state=BOOT, pc_out=RESET_PC, fetch_valid=0, flush=0, ext_ack=0, halted=0, drain counter=0.
- States: BOOT, RUN, DRAIN, HALT. fetch_valid=1 only in RUN. halted=1 only in HALT.
- BOOT: pc_out held; next state is RUN unconditionally. First valid fetch is RESET_PC one cycle after reset deasserts.
- Branch target = br_pc + (sext(offset) << 2).
  - offset is CondAddr19 or BrAddr26, per UncondBr.
  - Computed at ADDR_W bits, wrapping mod 2^ADDR_W.
- RUN: evaluate in priority order each cycle.
  1. ext_req=1 and ext_ack=0 -> DRAIN. pc_out held; counter cleared. A branch in the same cycle is ignored and flush=0.
  2. br_valid & BrTaken -> pc_out <= target next edge; flush=1 this cycle. Branch overrides stall and halt_req in the same cycle.
  3. halt_req -> HALT; pc_out held.
  4. stall -> pc_out held; fetch_valid stays 1.
  5. Otherwise pc_out <= pc_out + 4, wrapping 2^ADDR_W-4 -> 0.
  - br_valid & !BrTaken has no effect beyond normal advance.
- DRAIN:
  - fetch_valid=0, flush=0; branch, stall and halt_req inputs ignored. Counter increments each cycle.
  - In the cycle the counter equals DRAIN_CYCLES-1: pc_out <= pc_ext (sampled that cycle), ext_ack <= 1, next state RUN.
  - ext_req=1 is therefore seen for DRAIN_CYCLES cycles in DRAIN. The ack coincides with the first RUN cycle at pc_ext.
  - ext_req dropping before commit is a protocol violation: abort to RUN, pc_out unchanged, no ack.
- ext_ack: registered, exactly one cycle. ext_req still high during the ack cycle is not a new request. A request is recognised again from the following cycle.
- HALT: pc_out held; only ext_req leaves HALT (-> DRAIN, then RUN at pc_ext). All other inputs ignored.
- flush is asserted only in RUN with br_valid & BrTaken.

Decomposition:
- Shared package cpu_pkg:
  - pc_state_t enum {BOOT, RUN, DRAIN, HALT}
  - INSTR_BYTES = 4
  - BR_SHIFT = 2
- Sub-module branch_target_calc: combinational sign-extend of both offsets, UncondBr select, shift by BR_SHIFT, add br_pc; ADDR_W parameter.
- pc_sequencer holds the FSM, drain counter, PC register and ack register.

Test Plan:
- Reset then 5 idle cycles -> fetch_valid=0 in BOOT; then pc_out 0x0, 0x4, 0x8, 0xC in RUN, flush=0 throughout.
- RUN at pc 0x100; br_valid=1, BrTaken=1, UncondBr=0, CondAddr19=19'h7FFFE, br_pc=0xF8 -> flush=1 that cycle; next pc_out=0xF0. Same stimulus with stall=1 gives the same result.
- stall held 3 cycles at pc 0x40 -> pc_out stays 0x40 with fetch_valid=1; then advances to 0x44.
- pc_out=0x200, ext_req=1, pc_ext=0x8000, DRAIN_CYCLES=4 -> fetch_valid=0 for 4 cycles; then pc_out=0x8000 with ext_ack=1 for one cycle; ext_req held through the ack does not restart DRAIN.
- halt_req at pc 0x30 -> halted=1, pc_out 0x30 frozen for 10 cycles despite a taken branch input; ext_req with pc_ext=0x0 -> resumes at 0x0 after drain.
- reset asserted in the 2nd DRAIN cycle -> BOOT, pc_out=RESET_PC, no ext_ack. Separately, pc_out=0xFFFF_FFFF_FFFF_FFFC advancing -> wraps to 0x0.
